// File: rtl/eg_memory_sequencer.sv
// Envelope state memory sequencer: round-robin read/update/write-back
// over all slots, with host forced writes in a fixed window.
module eg_memory_sequencer #(
  parameter int NUM_SLOTS = 18,
  parameter int DW        = 25,
  parameter int AW        = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_wr,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          eg_rd_valid,
  output logic [AW-1:0] eg_slot,
  output logic [DW-1:0] eg_rd_data,
  input  logic          eg_upd_valid,
  input  logic [DW-1:0] eg_upd_data,
  input  logic          host_req,
  input  logic [AW-1:0] host_slot,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic          host_err,
  output logic          frame_start,
  output logic          init_done,
  output logic          upd_miss
);

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_t;

  localparam logic [AW-1:0] LAST = AW'(NUM_SLOTS - 1);
  localparam logic [AW-1:0] NSL  = AW'(NUM_SLOTS);

  phase_t        phase;
  logic [AW-1:0] cur_slot;
  logic [AW-1:0] init_cnt;
  logic          active;
  logic          init_q;
  logic          cap_valid;
  logic [DW-1:0] cap_data;
  logic          cancel;
  logic          miss_q;

  logic start;
  logic host_win;
  logic host_bad;
  logic host_wr;
  logic wb;

  // Period start is decided live at p0; p1..p3 use the latched flag.
  assign start    = (phase == P0) && init_q && run;
  assign host_win = (phase == P2) && init_q && host_req;
  assign host_bad = host_slot >= NSL;
  assign host_wr  = host_win && !host_bad;
  assign wb       = active && (phase == P3) && cap_valid && !cancel;

  assign mem_raddr   = start ? cur_slot : '0;
  assign frame_start = start && (cur_slot == '0);
  assign eg_rd_valid = active && (phase == P1);
  assign eg_slot     = active ? cur_slot : '0;
  assign eg_rd_data  = eg_rd_valid ? mem_rdata : '0;
  assign host_ack    = host_win;
  assign host_err    = host_win && host_bad;
  assign init_done   = init_q;
  assign upd_miss    = miss_q;

  // Host window (p2) and write-back (p3) never overlap in time.
  assign mem_wr    = host_wr || wb;
  assign mem_waddr = host_wr ? host_slot :
                     wb      ? cur_slot  : '0;
  assign mem_wdata = host_wr ? host_wdata :
                     wb      ? cap_data   : '0;

  // Init wait, phase/slot sequencing, update capture and miss tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     <= P0;
      cur_slot  <= '0;
      init_cnt  <= '0;
      active    <= 1'b0;
      init_q    <= 1'b0;
      cap_valid <= 1'b0;
      cap_data  <= '0;
      cancel    <= 1'b0;
      miss_q    <= 1'b0;
    end else if (!init_q) begin
      if (init_cnt == LAST) begin
        init_q <= 1'b1;
      end else begin
        init_cnt <= init_cnt + 1'b1;
      end
    end else begin
      unique case (phase)
        P0: begin
          active    <= start;
          cap_valid <= 1'b0;
          cancel    <= 1'b0;
          phase     <= P1;
        end
        P1: begin
          phase <= P2;
        end
        P2: begin
          if (active && host_wr && (host_slot == cur_slot)) begin
            cancel <= 1'b1;
          end
          if (active && !cap_valid && !eg_upd_valid) begin
            miss_q <= 1'b1;
          end
          phase <= P3;
        end
        P3: begin
          if (active) begin
            cur_slot <= (cur_slot == LAST) ? '0 : cur_slot + 1'b1;
          end
          active <= 1'b0;
          phase  <= P0;
        end
        default: phase <= P0;
      endcase
      if (active && ((phase == P1) || (phase == P2)) &&
          eg_upd_valid && !cap_valid) begin
        cap_valid <= 1'b1;
        cap_data  <= eg_upd_data;
      end
    end
  end

endmodule

// File: tb/tb_eg_memory_sequencer.sv
// Directed bench for eg_memory_sequencer with a behavioral
// 1-cycle-latency envelope memory and a +1 update model.
module tb_eg_memory_sequencer;

  localparam int NS = 18;
  localparam int DW = 25;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_wr;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          eg_rd_valid;
  logic [AW-1:0] eg_slot;
  logic [DW-1:0] eg_rd_data;
  logic          eg_upd_valid;
  logic [DW-1:0] eg_upd_data;
  logic          host_req;
  logic [AW-1:0] host_slot;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic          host_err;
  logic          frame_start;
  logic          init_done;
  logic          upd_miss;

  eg_memory_sequencer #(.NUM_SLOTS(NS), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .eg_rd_valid(eg_rd_valid), .eg_slot(eg_slot),
    .eg_rd_data(eg_rd_data),
    .eg_upd_valid(eg_upd_valid), .eg_upd_data(eg_upd_data),
    .host_req(host_req), .host_slot(host_slot),
    .host_wdata(host_wdata),
    .host_ack(host_ack), .host_err(host_err),
    .frame_start(frame_start), .init_done(init_done),
    .upd_miss(upd_miss)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [NS];
  bit withhold;

  // Envelope memory: all-ones after reset, registered read.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NS; i++) mem[i] <= '1;
      mem_rdata <= '0;
    end else begin
      if (mem_raddr < AW'(NS)) mem_rdata <= mem[mem_raddr];
      if (mem_wr && mem_waddr < AW'(NS)) mem[mem_waddr] <= mem_wdata;
    end
  end

  // Update logic: returns stored word + 1 during p1.
  always @(negedge clk) begin
    eg_upd_valid = eg_rd_valid && !(withhold && eg_slot == 5'd7);
    eg_upd_data  = eg_rd_data + 25'd1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int ph, sl;
  bit act;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ph = (ph + 1) % 4;
    if (ph == 0) begin
      if (act) sl = (sl + 1) % NS;
      act = run;
    end
  endtask

  task automatic goto(input int s, input int p);
    bit hit = 0;
    for (int i = 0; i < 400; i++) begin
      if (sl == s && ph == p) begin
        hit = 1;
        break;
      end
      tick();
    end
    check("goto_reached", 32'(hit), 32'd1);
  endtask

  task automatic do_init();
    int wrs = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (mem_wr) wrs++;
      if (i == 17) check("init_not_yet", 32'(init_done), 32'd0);
    end
    check("init_done", 32'(init_done), 32'd1);
    check("init_no_wr", 32'(wrs), 32'd0);
    check("first_frame", 32'(frame_start), 32'd1);
    check("first_raddr", 32'(mem_raddr), 32'd0);
    ph  = 0;
    sl  = 0;
    act = run;
  endtask

  initial begin
    int good;
    int extra;
    reset      = 1'b1;
    run        = 1'b1;
    host_req   = 1'b0;
    host_slot  = '0;
    host_wdata = '0;
    withhold   = 0;
    repeat (3) @(negedge clk);
    check("rst_wr", 32'(mem_wr), 32'd0);
    check("rst_init", 32'(init_done), 32'd0);
    check("rst_frame", 32'(frame_start), 32'd0);
    check("rst_miss", 32'(upd_miss), 32'd0);
    do_init();

    // Frame 1: every slot reads all-ones and writes back zero.
    good  = 0;
    extra = 0;
    for (int k = 0; k < 72; k++) begin
      if (ph == 3) begin
        if (mem_wr && mem_waddr == AW'(sl) && mem_wdata == '0) good++;
      end else if (mem_wr) begin
        extra++;
      end
      tick();
    end
    check("f1_writebacks", 32'(good), 32'd18);
    check("f1_extra_wr", 32'(extra), 32'd0);
    check("f2_frame", 32'(frame_start), 32'd1);
    tick();
    check("f2_rd_valid", 32'(eg_rd_valid), 32'd1);
    check("f2_rd_s0", 32'(eg_rd_data), 32'd0);

    // Host write to another slot while slot 3 is in flight.
    goto(3, 1);
    host_req = 1'b1; host_slot = 5'd9; host_wdata = 25'h00AAAAA;
    tick();
    check("h9_ack", 32'(host_ack), 32'd1);
    check("h9_waddr", 32'(mem_waddr), 32'd9);
    check("h9_wdata", 32'(mem_wdata), 32'h00AAAAA);
    tick();
    host_req = 1'b0;
    check("s3_wb_wr", 32'(mem_wr), 32'd1);
    check("s3_wb_addr", 32'(mem_waddr), 32'd3);
    check("s3_wb_data", 32'(mem_wdata), 32'd1);

    // Host write colliding with the slot in flight.
    goto(5, 1);
    check("s5_rd", 32'(eg_slot), 32'd5);
    host_req = 1'b1; host_slot = 5'd5; host_wdata = 25'h0123456;
    tick();
    check("h5_ack", 32'(host_ack), 32'd1);
    check("h5_wr", 32'(mem_wr), 32'd1);
    check("h5_waddr", 32'(mem_waddr), 32'd5);
    check("h5_wdata", 32'(mem_wdata), 32'h0123456);
    tick();
    host_req = 1'b0;
    check("h5_no_wb", 32'(mem_wr), 32'd0);
    tick();
    check("h5_ack_1clk", 32'(host_ack), 32'd0);

    // Missed update on slot 7.
    goto(7, 0);
    check("miss_pre", 32'(upd_miss), 32'd0);
    withhold = 1;
    goto(7, 3);
    check("miss_no_wb", 32'(mem_wr), 32'd0);
    check("miss_set", 32'(upd_miss), 32'd1);
    withhold = 0;
    goto(8, 3);
    check("s8_wb_addr", 32'(mem_waddr), 32'd8);
    check("s8_wb_data", 32'(mem_wdata), 32'd1);
    check("miss_sticky", 32'(upd_miss), 32'd1);
    goto(9, 1);
    check("s9_rd", 32'(eg_rd_data), 32'h00AAAAA);

    // Out-of-range host slot.
    goto(11, 1);
    host_req = 1'b1; host_slot = 5'd20; host_wdata = 25'h1555555;
    tick();
    check("bad_ack", 32'(host_ack), 32'd1);
    check("bad_err", 32'(host_err), 32'd1);
    check("bad_no_wr", 32'(mem_wr), 32'd0);
    tick();
    host_req = 1'b0;
    check("s11_wb", 32'(mem_wdata), 32'd1);

    // Frame 3: run drop in p1 of slot 4.
    goto(0, 0);
    check("f3_frame", 32'(frame_start), 32'd1);
    goto(4, 1);
    run = 1'b0;
    goto(4, 3);
    check("s4_wb_wr", 32'(mem_wr), 32'd1);
    check("s4_wb_addr", 32'(mem_waddr), 32'd4);
    check("s4_wb_data", 32'(mem_wdata), 32'd2);
    tick();
    check("idle_raddr", 32'(mem_raddr), 32'd0);
    tick();
    check("idle_no_rd", 32'(eg_rd_valid), 32'd0);
    host_req = 1'b1; host_slot = 5'd2; host_wdata = 25'h0000ABC;
    tick();
    check("idle_ack", 32'(host_ack), 32'd1);
    check("idle_hwaddr", 32'(mem_waddr), 32'd2);
    tick();
    host_req = 1'b0;
    check("idle_no_wb", 32'(mem_wr), 32'd0);
    tick();
    tick();
    run = 1'b1;
    goto(5, 0);
    check("resume_raddr", 32'(mem_raddr), 32'd5);
    tick();
    check("resume_rd", 32'(eg_rd_data), 32'h0123456);
    tick();

    // Reset in p2.
    reset = 1'b1;
    #1;
    check("mid_rst_init", 32'(init_done), 32'd0);
    check("mid_rst_miss", 32'(upd_miss), 32'd0);
    check("mid_rst_rdv", 32'(eg_rd_valid), 32'd0);
    do_init();
    tick();
    check("reinit_rd", 32'(eg_rd_data), 32'h1FFFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eg_memory_sequencer.md
Name: eg_memory_sequencer

Overview:
- Time-division controller for the 18-slot envelope state memory (1-cycle read latency, 25-bit words: 2-bit EG state + 23-bit phase).
- Steps round-robin through slots with a 4-clock read/update/write-back period and presents each slot's stored state to the envelope update logic.
- Writes the updated word back and interleaves host (register-interface) forced writes with defined priority.
- Sits between the envelope update datapath, the register decoder and the envelope memory.

Parameters:
NUM_SLOTS, 18, number of slots sequenced and entries in the memory
DW, 25, envelope data word width
AW, 5, slot address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
run  in  1  enable sequencing; sampled only at a period boundary
mem_raddr  out  AW  memory read address
mem_rdata  in  DW  memory read data, valid one clock after mem_raddr is sampled
mem_wr  out  1  memory write strobe
mem_waddr  out  AW  memory write address
mem_wdata  out  DW  memory write data
eg_rd_valid  out  1  stored word for eg_slot is on eg_rd_data
eg_slot  out  AW  slot currently in flight
eg_rd_data  out  DW  stored envelope word for eg_slot
eg_upd_valid  in  1  update logic result valid
eg_upd_data  in  DW  updated envelope word
host_req  in  1  host forced-write request; held until host_ack
host_slot  in  AW  host target slot
host_wdata  in  DW  host write data
host_ack  out  1  one-clock acknowledge
host_err  out  1  one-clock pulse with host_ack when host_slot >= NUM_SLOTS
frame_start  out  1  one-clock pulse at phase 0 of slot 0
init_done  out  1  memory init sweep complete
upd_miss  out  1  sticky flag: update not delivered in time

Behaviour:
- Reset: all outputs 0, cur_slot=0, phase=0, init counter=0, upd_miss=0. Reset mid-operation discards the in-flight slot and restarts the init wait.
- Init: after reset deassertion, wait NUM_SLOTS clocks with mem_wr=0, which covers the memory's own all-ones fill sweep. Then init_done=1 and stays 1.
- Requests during init: host_req is held pending; no ack.
- Period: 4 phases p0..p3 per slot, tracked by a 2-bit phase counter.
- Sequencing condition: a period starts only if init_done=1 and run=1 at p0. Otherwise the controller idles at p0 with cur_slot held.
- Period wrap: cur_slot increments after p3 and wraps NUM_SLOTS-1 -> 0.
- p0: mem_raddr=cur_slot; frame_start=1 if cur_slot=0.
- p1: eg_rd_valid=1, eg_slot=cur_slot, eg_rd_data=mem_rdata (pass-through).
- Update capture: eg_upd_valid is accepted in p1 or p2 and eg_upd_data is captured. First assertion wins; later assertions in the same period are ignored.
- p2 (host window): if host_req is pending, host_ack=1 for this clock.
  - Valid host_slot: mem_wr=1, mem_waddr=host_slot, mem_wdata=host_wdata.
  - host_slot >= NUM_SLOTS: host_err=1 and no write.
  - At most one host write per period.
- p3 (write-back): if an update was captured and no cancel applies, mem_wr=1, mem_waddr=cur_slot, mem_wdata=captured data.
- Collision rule: a host write in p2 targeting cur_slot cancels that slot's p3 write-back, so the host write wins.
- Missed update: if no update was captured by end of p2, there is no write-back and upd_miss is set (cleared only by reset).
- Write exclusivity: mem_wr is high only in p2 or p3; never two writes in one clock.
- run deassertion: takes effect at the next p0. The current period always completes, including its write-back.
- Host latency: the worst case from host_req to host_ack is 4 clocks once sequencing is running.
- Idle host service: while idle (run=0, init_done=1) the phase counter still cycles and the host window is still served. Only read, eg_rd_valid and write-back are suppressed.

Test Plan:
- Init: release reset, run=1 -> mem_wr=0 for 18 clocks; init_done rises on clock 18; first frame_start follows with mem_raddr=0.
- Steady state: update logic returns rdata+1 in p1 -> each slot written back in p3 with waddr=slot. After one frame (72 clocks) memory holds 0x0000000 everywhere, since 0x1FFFFFF+1 wraps at 25 bits. Slot 17 is followed by slot 0 with a frame_start pulse.
- Host collision: host_req with host_slot=cur_slot=5, host_wdata=0x0123456 -> p2 write of 0x0123456 to 5, no p3 write, host_ack 1 clock. Next frame reads 0x0123456.
- Host other slot / bad slot: host_slot=9 while slot 3 is in flight -> p2 write to 9 and slot 3 write-back still occurs. host_slot=20 -> host_ack+host_err, mem_wr=0 in p2.
- Missed update: withhold eg_upd_valid for slot 7 -> no p3 write, upd_miss=1 and stays set; later slots unaffected.
- run/reset: drop run in p1 of slot 4 -> slot 4 write-back completes, then idle with raddr pulses stopped; restore run -> resumes at slot 5. Assert reset at p2 -> outputs 0 immediately, init wait restarts.
